// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB endpoint buffers.
package usb_ep_pkg;

  // Receive-side endpoint FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone,
    StDiscard
  } ep_state_e;

  // Default wMaxPacketSize for bulk endpoints at high and full speed.
  localparam int unsigned MaxPacketHs = 512;
  localparam int unsigned MaxPacketFs = 64;

endpackage

// File: rtl/usb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module usb_sdp_ram #(
  parameter int unsigned ABITS = 11,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ABITS-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**ABITS];
  logic [WIDTH-1:0] rd_data_q;

  // Write and registered read; read data holds while rd_en is low.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bulk_ep_out.sv
// Bulk OUT endpoint buffer: holds each received packet tentatively until the
// protocol layer commits or drops it, then streams committed bytes out as AXIS.
module bulk_ep_out
  import usb_ep_pkg::*;
#(
  parameter int unsigned MAX_PACKET_SIZE = MaxPacketHs,
  parameter int unsigned ABITS           = 11
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         bulk_ep_out_xfer_i,
  output logic         bulk_ep_out_has_space_o,
  input  logic         bulk_ep_out_tvalid_i,
  output logic         bulk_ep_out_tready_o,
  input  logic         bulk_ep_out_tlast_i,
  input  logic [7:0]   bulk_ep_out_tdata_i,
  input  logic         bulk_ep_out_commit_i,
  input  logic         bulk_ep_out_drop_i,
  output logic         bulk_ep_out_overflow_o,
  output logic         axis_tvalid_o,
  input  logic         axis_tready_i,
  output logic         axis_tlast_o,
  output logic [7:0]   axis_tdata_o,
  output logic [ABITS:0] level_o
);

  localparam int unsigned PW = ABITS + 1;
  localparam logic [ABITS:0] Depth  = PW'(2 ** ABITS);
  localparam logic [ABITS:0] MaxPkt = PW'(MAX_PACKET_SIZE);
  localparam logic [ABITS:0] One    = PW'(1);

  ep_state_e      state_q;
  logic [ABITS:0] wr_ptr_q, wr_commit_q, rd_ptr_q;
  logic           has_space_q, overflow_q;
  logic           ram_valid_q, out_valid_q, out_last_q;
  logic [7:0]     out_data_q;

  logic [ABITS:0] free_cnt, pkt_cnt;
  logic           full, empty, wr_en, pop, load_out, rd_issue;
  logic [8:0]     ram_rd_data;

  // Pointer arithmetic and write/read handshakes.
  always_comb begin
    free_cnt = Depth - (wr_ptr_q - rd_ptr_q);
    pkt_cnt  = wr_ptr_q - wr_commit_q;
    full     = (wr_ptr_q[ABITS] != rd_ptr_q[ABITS]) &&
               (wr_ptr_q[ABITS-1:0] == rd_ptr_q[ABITS-1:0]);
    empty    = (rd_ptr_q == wr_commit_q);
    // The byte that would exceed the packet limit is never written.
    wr_en    = (state_q == StRecv) && bulk_ep_out_tvalid_i && bulk_ep_out_xfer_i &&
               !bulk_ep_out_drop_i && !bulk_ep_out_commit_i && (pkt_cnt != MaxPkt) && !full;
    pop      = out_valid_q && axis_tready_i;
    load_out = ram_valid_q && (!out_valid_q || pop);
    rd_issue = !empty && (!ram_valid_q || load_out);
  end

  // Receive FSM: tentative write pointer, commit pointer, space and overflow flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      has_space_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      case (state_q)
        StIdle: begin
          has_space_q <= (free_cnt >= MaxPkt);
          if (bulk_ep_out_xfer_i) begin
            state_q <= has_space_q ? StRecv : StDiscard;
          end
        end
        StRecv: begin
          // A commit before tlast carries no complete packet; nothing is kept.
          if (bulk_ep_out_drop_i || !bulk_ep_out_xfer_i || bulk_ep_out_commit_i) begin
            wr_ptr_q <= wr_commit_q;
            state_q  <= StIdle;
          end else if (bulk_ep_out_tvalid_i) begin
            if (pkt_cnt == MaxPkt) begin
              overflow_q <= 1'b1;
              wr_ptr_q   <= wr_commit_q;
              state_q    <= StDiscard;
            end else begin
              wr_ptr_q <= wr_ptr_q + One;
              if (bulk_ep_out_tlast_i) begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          if (bulk_ep_out_drop_i || (!bulk_ep_out_commit_i && !bulk_ep_out_xfer_i)) begin
            wr_ptr_q <= wr_commit_q;
            state_q  <= StIdle;
          end else if (bulk_ep_out_commit_i) begin
            wr_commit_q <= wr_ptr_q;
            state_q     <= StIdle;
          end
        end
        StDiscard: begin
          if (!bulk_ep_out_xfer_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  usb_sdp_ram #(
    .ABITS (ABITS),
    .WIDTH (9)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ABITS-1:0]),
    .wr_data ({bulk_ep_out_tlast_i, bulk_ep_out_tdata_i}),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_q[ABITS-1:0]),
    .rd_data (ram_rd_data)
  );

  // Read pipeline: RAM read in flight plus one-entry output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      ram_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr_q    <= rd_ptr_q + One;
        ram_valid_q <= 1'b1;
      end else if (load_out) begin
        ram_valid_q <= 1'b0;
      end
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_last_q  <= ram_rd_data[8];
        out_data_q  <= ram_rd_data[7:0];
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bulk_ep_out_has_space_o = has_space_q;
  assign bulk_ep_out_tready_o    = (state_q == StRecv) || (state_q == StDiscard);
  assign bulk_ep_out_overflow_o  = overflow_q;
  assign axis_tvalid_o           = out_valid_q;
  assign axis_tlast_o            = out_last_q;
  assign axis_tdata_o            = out_data_q;
  assign level_o                 = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_bulk_ep_out.sv
// Scoreboard bench for bulk_ep_out: committed packets are queued as expected
// beats and a separate monitor compares every accepted AXIS beat.
module tb_bulk_ep_out;

  localparam int unsigned Abits  = 11;
  localparam int unsigned MaxPkt = 512;
  localparam int ActCommit = 0;
  localparam int ActDrop   = 1;
  localparam int ActNone   = 2;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic           xfer = 1'b0, tvalid = 1'b0, tlast = 1'b0, commit = 1'b0, drop = 1'b0;
  logic [7:0]     tdata = '0;
  logic           axis_tready = 1'b0;
  logic           has_space, tready, overflow, axis_tvalid, axis_tlast;
  logic [7:0]     axis_tdata;
  logic [Abits:0] level;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int ovf_count = 0;
  int level_max = 0;
  int sink_mode = 0;  // 0: stalled, 1: always ready, 2: random
  logic [8:0] exp_q[$];

  bulk_ep_out #(
    .MAX_PACKET_SIZE (MaxPkt),
    .ABITS           (Abits)
  ) u_dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .bulk_ep_out_xfer_i      (xfer),
    .bulk_ep_out_has_space_o (has_space),
    .bulk_ep_out_tvalid_i    (tvalid),
    .bulk_ep_out_tready_o    (tready),
    .bulk_ep_out_tlast_i     (tlast),
    .bulk_ep_out_tdata_i     (tdata),
    .bulk_ep_out_commit_i    (commit),
    .bulk_ep_out_drop_i      (drop),
    .bulk_ep_out_overflow_o  (overflow),
    .axis_tvalid_o           (axis_tvalid),
    .axis_tready_i           (axis_tready),
    .axis_tlast_o            (axis_tlast),
    .axis_tdata_o            (axis_tdata),
    .level_o                 (level)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sink: drives axis_tready according to sink_mode.
  initial forever begin
    @(posedge clock);
    #1;
    case (sink_mode)
      1:       axis_tready = 1'b1;
      2:       axis_tready = 1'($urandom_range(0, 1));
      default: axis_tready = 1'b0;
    endcase
  end

  // Monitor: scoreboard compare, stall stability, overflow and level tracking.
  initial begin : monitor
    bit         prev_stall;
    logic [8:0] prev_beat;
    logic [8:0] got;
    logic [8:0] exp;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      got = {axis_tlast, axis_tdata};
      if (prev_stall) begin
        vectors++;
        if (!(axis_tvalid === 1'b1 && got === prev_beat)) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%0b beat=%03h, expected valid=1 beat=%03h",
                   axis_tvalid, got, prev_beat);
        end
      end
      prev_stall = axis_tvalid && !axis_tready;
      prev_beat  = got;
      if (axis_tvalid && axis_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat %0d: got last=%0b data=%02h, expected no beat",
                   pops, axis_tlast, axis_tdata);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL beat %0d: got last=%0b data=%02h, expected last=%0b data=%02h",
                     pops, got[8], got[7:0], exp[8], exp[7:0]);
          end
        end
        pops++;
      end
      if (overflow) ovf_count++;
      if (int'(level) > level_max) level_max = int'(level);
    end
  end

  // One OUT transaction: xfer, len bytes (tlast on the last), then the closing action.
  task automatic run_pkt(input int len, input bit rnd, input int action, input bit keep);
    logic [8:0] pkt[$];
    int b;
    xfer = 1'b1;
    tick(1);
    for (int i = 0; i < len; i++) begin
      tvalid = 1'b1;
      tdata  = rnd ? 8'($urandom) : 8'(i);
      tlast  = (i == len - 1);
      b = 0;
      while (!tready && b < 100) begin
        tick(1);
        b++;
      end
      if (!tready) begin
        check("tready_wait", 32'(tready), 1);
        break;
      end
      pkt.push_back({tlast, tdata});
      tick(1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    case (action)
      ActCommit: begin
        commit = 1'b1;
        xfer   = 1'b0;
        tick(1);
        commit = 1'b0;
      end
      ActDrop: begin
        drop = 1'b1;
        xfer = 1'b0;
        tick(1);
        drop = 1'b0;
      end
      default: begin
        xfer = 1'b0;
        tick(1);
      end
    endcase
    if (keep) begin
      foreach (pkt[j]) exp_q.push_back(pkt[j]);
    end
    tick(1);
  endtask

  task automatic wait_space();
    int b;
    b = 0;
    while (!has_space && b < 20000) begin
      tick(1);
      b++;
    end
    check("has_space_wait", 32'(has_space), 1);
  endtask

  task automatic drain(input string name);
    int b;
    sink_mode = 1;
    b = 0;
    while (exp_q.size() != 0 && b < 20000) begin
      tick(1);
      b++;
    end
    tick(4);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_level"}, 32'(level), 0);
    check({name, "_tvalid"}, 32'(axis_tvalid), 0);
  endtask

  initial begin : stimulus
    int target;
    int b;
    // Reset state.
    #2 reset_n = 1'b0;
    #2;
    check("rst_tready", 32'(tready), 0);
    check("rst_tvalid", 32'(axis_tvalid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(level), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_space", 32'(has_space), 1);
    check("post_rst_level", 32'(level), 0);

    // Good packet: 512 counting bytes, sink stalled so the level peaks.
    level_max = 0;
    run_pkt(512, 1'b0, ActCommit, 1'b1);
    tick(4);
    check("good_level_max", level_max, 512);
    // Output register plus one RAM read hold two bytes outside the count.
    check("good_level_stalled", 32'(level), 510);
    drain("good");

    // CRC fail, then a short good packet, then a zero-length commit.
    run_pkt(100, 1'b1, ActDrop, 1'b0);
    tick(4);
    check("crc_level", 32'(level), 0);
    check("crc_tvalid", 32'(axis_tvalid), 0);
    run_pkt(10, 1'b1, ActCommit, 1'b1);
    drain("after_crc");
    run_pkt(0, 1'b0, ActCommit, 1'b1);
    tick(4);
    check("zlp_level", 32'(level), 0);
    check("zlp_tvalid", 32'(axis_tvalid), 0);

    // Oversize: overflow on byte MaxPkt+1, the rest swallowed, nothing kept.
    ovf_count = 0;
    run_pkt(MaxPkt + 6, 1'b1, ActNone, 1'b0);
    tick(4);
    check("ovf_pulses", ovf_count, 1);
    check("ovf_level", 32'(level), 0);
    check("ovf_tvalid", 32'(axis_tvalid), 0);
    run_pkt(5, 1'b1, ActCommit, 1'b1);
    drain("after_ovf");

    // NAK: 1600 bytes held with the sink stalled leaves too little space.
    sink_mode = 0;
    for (int p = 0; p < 3; p++) begin
      check("nak_fill_space", 32'(has_space), 1);
      run_pkt(512, 1'b0, ActCommit, 1'b1);
    end
    run_pkt(64, 1'b1, ActCommit, 1'b1);
    tick(3);
    check("nak_space", 32'(has_space), 0);
    check("nak_level", 32'(level), 1598);
    run_pkt(20, 1'b1, ActCommit, 1'b0);
    tick(3);
    check("nak_discard_level", 32'(level), exp_q.size() - 2);
    target = pops + 64;
    sink_mode = 1;
    b = 0;
    while (pops < target && b < 500) begin
      tick(1);
      b++;
    end
    sink_mode = 0;
    check("nak_read64", 32'(pops >= target), 1);
    tick(3);
    check("nak_space_back", 32'(has_space), 1);

    // Wrap with random backpressure: 8 full-size random packets.
    sink_mode = 2;
    for (int p = 0; p < 8; p++) begin
      wait_space();
      run_pkt(512, 1'b1, ActCommit, 1'b1);
    end
    drain("wrap");

    // Reset in the middle of a packet with committed data still pending.
    sink_mode = 0;
    run_pkt(30, 1'b1, ActCommit, 1'b1);
    xfer = 1'b1;
    tick(1);
    check("mid_tready", 32'(tready), 1);
    tvalid = 1'b1;
    for (int i = 0; i < 37; i++) begin
      tdata = 8'(i);
      tick(1);
    end
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_tready", 32'(tready), 0);
    check("mid_rst_tvalid", 32'(axis_tvalid), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_space", 32'(has_space), 0);
    exp_q.delete();
    xfer   = 1'b0;
    tvalid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("mid_post_space", 32'(has_space), 1);
    check("mid_post_level", 32'(level), 0);
    run_pkt(16, 1'b1, ActCommit, 1'b1);
    drain("after_mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
